prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
- Parametrised, writable program memory for the CPU instruction fetch path.
- Replaces the fixed combinational program table with a RAM array, loaded at run time through a word-serial valid/ready loader port.
- Holds the CPU (`cpu_hold`) while a load is in progress and reports word count and an additive checksum so the bench or host can confirm the image.
- The fetch side keeps a combinational read so the CPU's single-cycle fetch timing is unchanged.

Parameters:
- ADDR_W, 4, fetch/load address width; DEPTH = 2**ADDR_W words
- DATA_W, 8, instruction word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  ADDR_W  CPU fetch address
- rd_data  out  DATA_W  instruction at rd_addr (combinational)
- ld_start  in  1  one-cycle request to begin a load
- ld_abort  in  1  terminate the current load
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_last  in  1  qualifies the final word of the image
- ld_ready  out  1  memory accepts ld_data this cycle
- cpu_hold  out  1  CPU must stall / stay reset
- ld_count  out  ADDR_W+1  words written in the current/last load
- ld_csum  out  DATA_W  sum of loaded words, mod 2**DATA_W
- ld_done  out  1  last load completed normally (sticky until next ld_start)
- ld_err  out  1  last load aborted or overflowed (sticky until next ld_start)

Behaviour:
- Reset (async assert, sync release to the clk domain):
  - state=IDLE; all memory words = 0; write pointer wp=0.
  - ld_count=0, ld_csum=0, ld_done=0, ld_err=0, ld_ready=0, cpu_hold=0.
- Read path:
  - rd_data = mem[rd_addr] combinationally in IDLE.
  - While cpu_hold=1, rd_data=0.
  - A write lands on the clock edge and is visible on the read path from the next cycle.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - ld_ready=0, cpu_hold=0.
  - ld_valid is ignored.
  - ld_start=1 -> LOAD; same edge: wp=0, ld_count=0, ld_csum=0, ld_done=0, ld_err=0.
- LOAD:
  - ld_ready=1, cpu_hold=1.
  - Handshake: a word transfers on any edge with ld_valid&ld_ready. Then mem[wp]=ld_data, wp=wp+1, ld_count+=1, ld_csum+=ld_data (truncated to DATA_W).
  - Accepted word with ld_last=1 -> FLUSH, ld_done set.
  - Accepted word at wp=DEPTH-1 without ld_last -> FLUSH, ld_done set (image fills memory exactly; ld_count=DEPTH).
  - ld_abort=1 -> FLUSH, ld_err set. Any word presented in that same cycle is NOT written.
  - ld_start during LOAD is ignored.
  - ld_valid held low indefinitely simply waits (no timeout).
- FLUSH:
  - One cycle: ld_ready=0, cpu_hold=1, then -> IDLE.
  - Gives the CPU a clean release after the final write.
  - Words presented in FLUSH are dropped; if ld_valid=1 in FLUSH after a DEPTH-full load, set ld_err (overflow); ld_done stays set.
- Contents not written by a load keep their previous values; memory is not cleared by ld_start.
- ld_count and ld_csum hold their final values in IDLE until the next ld_start.
- Reset mid-load: immediate return to reset state; memory is cleared, so a partial image is never executed.
- ld_start and ld_abort together in IDLE: ld_start wins, abort ignored.

Test Plan:
- Reset with rst_n=0 at mid-cycle -> all outputs 0 immediately; rd_data=0 for all 16 rd_addr.
- ld_start, then stream 30 30 60 C0 5F F3 80 A0 with ld_last on A0, ld_valid toggled 1/0 every other cycle -> mem[0..7] match; ld_count=8, ld_csum=0xF2, ld_done=1, ld_err=0; cpu_hold high from the cycle after ld_start through FLUSH; rd_data at addr 5 = 0xF3 in IDLE.
- Load 16 words 0x01..0x10 with no ld_last, then keep ld_valid=1 -> ld_count=16, ld_csum=0x88, ld_done=1, ld_err=1; mem[15]=0x10; extra word dropped.
- Load 3 words 0xAA 0xBB 0xCC, assert ld_abort together with a 4th word 0xDD -> mem[0..2]=AA BB CC, mem[3] keeps its old value, ld_count=3, ld_err=1, ld_done=0.
- Assert rst_n=0 after 2 of 8 words are written -> state IDLE, cpu_hold=0, mem[0..15]=0, ld_count=0.
- Second load of 2 words over an 8-word image -> mem[0..1] new, mem[2..7] retained; ld_start pulses issued during LOAD are ignored.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Writable program memory with a word-serial valid/ready loader; fetch read stays combinational.
// Holds the CPU during a load and reports word count, additive checksum and done/error status.
module prog_mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                ld_start,
  input  logic                ld_abort,
  input  logic                ld_valid,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                cpu_hold,
  output logic [ADDR_W:0]     ld_count,
  output logic [DATA_W-1:0]   ld_csum,
  output logic                ld_done,
  output logic                ld_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          rst_sync;
  logic                rst_int_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wp;
  logic                full_load;
  logic                start_load;
  logic                wr_en;
  logic                set_done;
  logic                set_err;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    cpu_hold   = 1'b0;
    start_load = 1'b0;
    wr_en      = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_nxt  = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b1;
        // Abort takes priority: a word offered alongside it is discarded.
        if (ld_abort) begin
          state_nxt = FLUSH;
          set_err   = 1'b1;
        end else if (ld_valid) begin
          wr_en = 1'b1;
          if (ld_last || (&wp)) begin
            state_nxt = FLUSH;
            set_done  = 1'b1;
          end
        end
      end
      FLUSH: begin
        cpu_hold  = 1'b1;
        state_nxt = IDLE;
        if (ld_valid && full_load) set_err = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp        <= '0;
      ld_count  <= '0;
      ld_csum   <= '0;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
      full_load <= 1'b0;
    end else begin
      if (start_load) begin
        wp        <= '0;
        ld_count  <= '0;
        ld_csum   <= '0;
        ld_done   <= 1'b0;
        ld_err    <= 1'b0;
        full_load <= 1'b0;
      end
      if (wr_en) begin
        mem[wp]  <= ld_data;
        wp       <= wp + ADDR_W'(1);
        ld_count <= ld_count + (ADDR_W+1)'(1);
        ld_csum  <= ld_csum + ld_data;
        if (&wp) full_load <= 1'b1;
      end
      if (set_done) ld_done <= 1'b1;
      if (set_err)  ld_err  <= 1'b1;
    end
  end

  assign rd_data = cpu_hold ? '0 : mem[rd_addr];

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: loaded words are queued as they are sent and checked on readback.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       ld_start = 1'b0;
  logic       ld_abort = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_last = 1'b0;
  logic       ld_ready;
  logic       cpu_hold;
  logic [4:0] ld_count;
  logic [7:0] ld_csum;
  logic       ld_done;
  logic       ld_err;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tb_mem [16];
  logic [3:0] wp_m;
  int         checks = 0;
  int         fails = 0;

  prog_mem_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .ld_start(ld_start), .ld_abort(ld_abort), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .cpu_hold(cpu_hold), .ld_count(ld_count), .ld_csum(ld_csum),
    .ld_done(ld_done), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [3:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #2;
    check($sformatf("rd_data[%0d]", addr), {24'd0, rd_data}, {24'd0, exp});
    tick();
  endtask

  task automatic drain_queue();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd_check(e.addr, e.data);
    end
  endtask

  task automatic start_load();
    check("cpu_hold idle", {31'd0, cpu_hold}, 32'd0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    wp_m = '0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic gap);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    #2;
    check("ld_ready load", {31'd0, ld_ready}, 32'd1);
    check("cpu_hold load", {31'd0, cpu_hold}, 32'd1);
    tick();
    exp_q.push_back('{addr: wp_m, data: d});
    tb_mem[wp_m] = d;
    wp_m = wp_m + 4'd1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (gap) begin
      #2;
      check("cpu_hold gap", {31'd0, cpu_hold}, 32'd1);
      tick();
    end
  endtask

  task automatic check_status(input string tag, input logic [4:0] cnt, input logic [7:0] cs,
                              input logic dn, input logic er);
    check({tag, " count"}, {27'd0, ld_count}, {27'd0, cnt});
    check({tag, " csum"},  {24'd0, ld_csum},  {24'd0, cs});
    check({tag, " done"},  {31'd0, ld_done},  {31'd0, dn});
    check({tag, " err"},   {31'd0, ld_err},   {31'd0, er});
  endtask

  logic [7:0] img [8];

  initial begin
    img = '{8'h30, 8'h30, 8'h60, 8'hC0, 8'h5F, 8'hF3, 8'h80, 8'hA0};
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    wp_m = '0;

    // Reset asserted mid-cycle: outputs must clear at once.
    repeat (2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check_status("rst", 5'd0, 8'h00, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) rd_check(4'(i), 8'h00);
    rst_n = 1'b1;
    repeat (3) tick();

    // 8-word image, valid toggling, ld_last on the final word.
    start_load();
    for (int i = 0; i < 8; i++) send(img[i], i == 7, i != 7);
    #2;
    check("flush cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("flush ld_ready", {31'd0, ld_ready}, 32'd0);
    check("flush rd_data", {24'd0, rd_data}, 32'd0);
    tick();
    check_status("img8", 5'd8, 8'hF2, 1'b1, 1'b0);
    rd_check(4'd5, 8'hF3);
    drain_queue();

    // Full 16-word image with no ld_last, valid kept high into FLUSH.
    start_load();
    for (int i = 0; i < 16; i++) send(8'(i + 1), 1'b0, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    #2;
    check("ovf ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    ld_valid = 1'b0;
    check_status("full16", 5'd16, 8'h88, 1'b1, 1'b1);
    drain_queue();

    // Abort together with a fourth word.
    start_load();
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 8'hDD;
    ld_abort = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_abort = 1'b0;
    tick();
    check_status("abort", 5'd3, 8'h31, 1'b0, 1'b1);
    drain_queue();
    rd_check(4'd3, 8'h04);

    // Reset after two words of a load: memory and status clear.
    start_load();
    send(8'h77, 1'b0, 1'b0);
    send(8'h66, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("midrst count", {27'd0, ld_count}, 32'd0);
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    exp_q.delete();
    tick();
    for (int i = 0; i < 16; i++) rd_check(4'(i), tb_mem[i]);
    rst_n = 1'b1;
    repeat (3) tick();

    // 8-word image, then a 2-word reload with ld_start pulsed mid-load.
    start_load();
    for (int i = 0; i < 8; i++) send(8'(8'h11 + i), i == 7, 1'b0);
    tick();
    exp_q.delete();
    start_load();
    send(8'hE1, 1'b0, 1'b0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    send(8'hE2, 1'b1, 1'b0);
    tick();
    check_status("reload", 5'd2, 8'hC3, 1'b1, 1'b0);
    drain_queue();
    for (int i = 2; i < 8; i++) rd_check(4'(i), tb_mem[i]);
    rd_check(4'd7, 8'h18);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
